sprite_draw: RTL and testbench
==============================

SPRITE_DRAW -- requirements
Module: sprite_draw

Interface
REQ-001 Parameter CORDW, default 16, width of signed screen coordinates.
REQ-002 Parameter H_RES, default 640, active line width in pixels.
REQ-003 Parameter SPR_W, default 16, sprite width in pixels.
REQ-004 Parameter SPR_H, default 16, sprite height in lines.
REQ-005 Parameter COLRW, default 4, colour-index width; equals the sprite ROM data width.
REQ-006 Parameter TRANSP, default 0, colour index treated as transparent.
REQ-007 Localparam ADDRW SHALL equal $clog2(SPR_W*SPR_H), matching the sprite ROM address width.
REQ-008 clk  input  1  sole clock; all state updates on the rising edge.
REQ-009 rst  input  1  asynchronous, active-high reset.
REQ-010 line  input  1  one-cycle pulse at the start of each line, during horizontal blanking.
REQ-011 sx  input  CORDW signed  current horizontal screen position from display timing.
REQ-012 sy  input  CORDW signed  current vertical screen position from display timing.
REQ-013 sprx  input  CORDW signed  sprite left edge, sampled once per line.
REQ-014 spry  input  CORDW signed  sprite top edge, sampled once per line.
REQ-015 rom_data  input  COLRW  colour index returned combinationally by the sprite ROM.
REQ-016 rom_addr  output  ADDRW  registered address driven to the sprite ROM.
REQ-017 pix  output  COLRW  registered colour index of the current sprite pixel.
REQ-018 drawing  output  1  high when pix is an opaque sprite pixel.

Function
REQ-019 The FSM SHALL have states IDLE, REG_POS, ACTIVE, WAIT_POS, SPR_LINE, LINE_END.
REQ-020 IDLE -> REG_POS when line=1; otherwise hold.
REQ-021 REG_POS SHALL latch sprx/spry into sprx_r/spry_r, then -> ACTIVE.
REQ-022 ACTIVE SHALL compute row = sy - spry_r; if 0 <= row <= SPR_H-1, set rom_addr = row*SPR_W and -> WAIT_POS; else -> IDLE.
REQ-023 WAIT_POS -> SPR_LINE on the cycle sx == sprx_r - 1; otherwise hold.
REQ-024 In SPR_LINE a pixel counter bx (0..SPR_W-1) SHALL increment each cycle and rom_addr SHALL increment with it; at bx == SPR_W-1 -> LINE_END.
REQ-025 LINE_END -> IDLE after one cycle.
REQ-026 In each SPR_LINE cycle pix SHALL register rom_data and drawing SHALL register (rom_data != TRANSP); in all other states pix and drawing SHALL be registered to 0.
REQ-027 Latency: pix/drawing for screen column c SHALL be valid in the cycle sx == c+1 (exactly one cycle behind sx).
REQ-028 Exactly SPR_W pixels SHALL be emitted per drawn line; rom_addr SHALL never exceed SPR_W*SPR_H-1.
REQ-029 The row test SHALL use full signed CORDW+1-bit arithmetic; negative spry and sy < spry_r SHALL not wrap.
REQ-030 Left clip: if sprx_r - 1 lies before the sx value seen on WAIT_POS entry, the line SHALL NOT be drawn (FSM stays in WAIT_POS until the next line pulse).
REQ-031 Right overrun past H_RES-1 SHALL be emitted unchanged; downstream masks blanking.
REQ-032 A line pulse in any state other than IDLE SHALL abort the current line, force pix/drawing to 0, and -> REG_POS.
REQ-033 Changes to sprx/spry outside REG_POS SHALL have no effect until the next line.

Reset
REQ-034 On rst the FSM SHALL enter IDLE; rom_addr, pix, drawing, bx, sprx_r, spry_r SHALL be 0, asynchronously.
REQ-035 After rst is released, no pixel SHALL be drawn before the first line pulse.

Structure
REQ-036 The FSM state enumeration and TRANSP default SHALL live in the shared video package.
REQ-037 The block SHALL be a single module with no sub-modules; the sprite ROM is instantiated alongside it by the parent.

Verification (SPR_W=SPR_H=8, COLRW=4, ROM word n = n[3:0], TRANSP=0)
REQ-038 sprx=100, spry=50, sy=50 -> rom_addr 0..7 during sx 100..107; pix 0..7 at sx 101..108; drawing low at sx 101 (index 0), high at sx 102..108.
REQ-039 sy=53, same sprite -> rom_addr 24..31; pix 8..15 (24..31 mod 16); drawing high for all 8 pixels.
REQ-040 sy=49 and sy=58 -> FSM returns to IDLE from ACTIVE; drawing stays 0 for the whole line.
REQ-041 spry=-3, sy=0 -> row 3 drawn (rom_addr 24..31); sy=5 -> not drawn.
REQ-042 line pulse at sx=103 mid-draw -> pix/drawing 0 next cycle; FSM in REG_POS; no further pixels that line.
REQ-043 rst asserted at sx=104 -> all outputs 0 immediately; nothing drawn until the next line pulse after release.

Source files
------------

// File: rtl/sprite_draw_pkg.sv
// Shared video types: sprite line FSM states and the default transparent colour index.
package sprite_draw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REG_POS,
    ACTIVE,
    WAIT_POS,
    SPR_LINE,
    LINE_END
  } spr_state_t;

  localparam int TRANSP_DEF = 0;

endpackage

// File: rtl/sprite_draw.sv
// Sprite line drawer: fetches one sprite row per line and emits pix/drawing one cycle behind sx.
// No backpressure; the display timing paces everything and the ROM answers combinationally.
module sprite_draw
  import sprite_draw_pkg::*;
#(
  parameter int CORDW  = 16,
  parameter int H_RES  = 640,
  parameter int SPR_W  = 16,
  parameter int SPR_H  = 16,
  parameter int COLRW  = 4,
  parameter int TRANSP = TRANSP_DEF,
  localparam int ADDRW = $clog2(SPR_W*SPR_H)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    line,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic signed [CORDW-1:0] sprx,
  input  logic signed [CORDW-1:0] spry,
  input  logic [COLRW-1:0]        rom_data,
  output logic [ADDRW-1:0]        rom_addr,
  output logic [COLRW-1:0]        pix,
  output logic                    drawing
);

  localparam int BXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam logic [BXW-1:0]   BX_LAST  = BXW'(SPR_W - 1);
  localparam logic [COLRW-1:0] TRANSP_C = COLRW'(TRANSP);

  if (SPR_W > H_RES) begin : g_bad_width
    $error("sprite_draw: sprite wider than the active line");
  end

  spr_state_t              state;
  logic signed [CORDW-1:0] sprx_r, spry_r;
  logic [BXW-1:0]          bx;
  logic                    wait_first, clipped;

  // One extra bit so sy - spry_r never wraps, even with negative positions.
  logic signed [CORDW:0] row, target, sx_w;
  logic                  row_ok;

  always_comb begin
    sx_w   = {sx[CORDW-1], sx};
    row    = {sy[CORDW-1], sy} - {spry_r[CORDW-1], spry_r};
    target = {sprx_r[CORDW-1], sprx_r} - (CORDW+1)'(1);
    row_ok = !row[CORDW] && (row < (CORDW+1)'(SPR_H));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      pix        <= '0;
      drawing    <= 1'b0;
      bx         <= '0;
      sprx_r     <= '0;
      spry_r     <= '0;
      wait_first <= 1'b0;
      clipped    <= 1'b0;
    end else begin
      pix     <= '0;
      drawing <= 1'b0;
      if (line) begin
        state <= REG_POS;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          REG_POS: begin
            sprx_r  <= sprx;
            spry_r  <= spry;
            clipped <= 1'b0;
            state   <= ACTIVE;
          end
          ACTIVE: begin
            if (row_ok) begin
              rom_addr   <= ADDRW'(row[ADDRW-1:0] * SPR_W);
              wait_first <= 1'b1;
              state      <= WAIT_POS;
            end else begin
              state <= IDLE;
            end
          end
          WAIT_POS: begin
            // A start column already behind us on entry means the line is skipped.
            wait_first <= 1'b0;
            if (!clipped && sx_w == target) begin
              bx    <= '0;
              state <= SPR_LINE;
            end else if (wait_first && sx_w > target) begin
              clipped <= 1'b1;
            end
          end
          SPR_LINE: begin
            pix     <= rom_data;
            drawing <= (rom_data != TRANSP_C);
            if (bx == BX_LAST) begin
              state <= LINE_END;
            end else begin
              bx       <= bx + 1'b1;
              rom_addr <= rom_addr + 1'b1;
            end
          end
          LINE_END: state <= IDLE;
          default:  state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_draw.sv
// Bench for sprite_draw: 8x8 sprite, ROM word n = n[3:0], colour 0 transparent.
module tb_sprite_draw;

  localparam int CORDW = 16;
  localparam int H_RES = 640;
  localparam int SPR_W = 8;
  localparam int SPR_H = 8;
  localparam int COLRW = 4;
  localparam int ADDRW = 6;
  localparam int LSTART = -20;
  localparam int LEND   = 129;
  localparam int LLEN   = LEND - LSTART + 1;
  localparam int NONE   = -1000;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    line;
  logic signed [CORDW-1:0] sx, sy, sprx, spry;
  logic [COLRW-1:0]        rom_data, pix;
  logic [ADDRW-1:0]        rom_addr;
  logic                    drawing;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_addr[3:0];

  sprite_draw #(
    .CORDW(CORDW), .H_RES(H_RES), .SPR_W(SPR_W), .SPR_H(SPR_H),
    .COLRW(COLRW), .TRANSP(0)
  ) dut (
    .clk(clk), .rst(rst), .line(line), .sx(sx), .sy(sy),
    .sprx(sprx), .spry(spry), .rom_data(rom_data),
    .rom_addr(rom_addr), .pix(pix), .drawing(drawing)
  );

  // Model: per line, position latched one edge after the pulse, row taken on
  // the next, start column checked against sx on the third; column c then
  // appears after the edge where sx == c.
  bit             m_live  = 1'b0;
  bit             m_drawn = 1'b0;
  int             m_n = 0, m_x = 0, m_y = 0, m_row = 0, m_entry = 0;
  logic [COLRW-1:0] exp_pix = '0;
  logic             exp_drw = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_live  = 1'b0;
      exp_pix = '0;
      exp_drw = 1'b0;
    end else begin
      exp_pix = '0;
      exp_drw = 1'b0;
      if (line) begin
        m_live = 1'b1;
        m_n    = 0;
      end else if (m_live) begin
        m_n++;
        if (m_n == 1) begin
          m_x = int'(sprx);
          m_y = int'(spry);
        end else if (m_n == 2) begin
          m_row = int'(sy) - m_y;
        end else if (m_n == 3) begin
          m_entry = int'(sx);
          m_drawn = (m_row >= 0) && (m_row < SPR_H) && (m_x - 1 >= m_entry);
        end else if (m_drawn && int'(sx) >= m_x && int'(sx) < m_x + SPR_W) begin
          exp_pix = COLRW'((m_row * SPR_W + int'(sx) - m_x) % 16);
          exp_drw = (exp_pix != 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    total++;
    if (pix !== exp_pix || drawing !== exp_drw) begin
      bad++;
      $display("FAIL model t=%0t sx=%0d: pix=%0d drawing=%0b, required pix=%0d drawing=%0b",
               $time, sx, pix, drawing, exp_pix, exp_drw);
    end
  end

  logic [COLRW-1:0] a_pix  [LLEN];
  logic             a_drw  [LLEN];
  logic [ADDRW-1:0] a_addr [LLEN];

  function automatic int at(input int x);
    return x - LSTART;
  endfunction

  function automatic int drawn_from(input int x);
    int n = 0;
    for (int i = at(x); i < LLEN; i++) if (a_drw[i]) n++;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One display line; optional mid-line line pulse, reset, or sprite move.
  task automatic run_line(input int y, input int px, input int py,
                          input int abort_sx, input int rst_sx, input int move_sx);
    for (int x = LSTART; x <= LEND; x++) begin
      @(posedge clk);
      #1;
      sx   = CORDW'(x);
      sy   = CORDW'(y);
      line = (x == LSTART) || (x == abort_sx);
      if (x == LSTART) begin
        sprx = CORDW'(px);
        spry = CORDW'(py);
      end
      if (x == move_sx) begin
        sprx = CORDW'(px - 50);
        spry = CORDW'(py + 3);
      end
      if (x == rst_sx) rst = 1'b1;
      else if (x == rst_sx + 2) rst = 1'b0;
      #3;
      a_pix[at(x)]  = pix;
      a_drw[at(x)]  = drawing;
      a_addr[at(x)] = rom_addr;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; line = 1'b0; sx = '0; sy = '0; sprx = '0; spry = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset pix", int'(pix), 0);
    chk("reset drawing", int'(drawing), 0);
    chk("reset rom_addr", int'(rom_addr), 0);
    rst = 1'b0;

    n = 0;
    for (int x = 90; x <= 115; x++) begin
      @(posedge clk);
      #1;
      sx = CORDW'(x); sy = 16'sd50; sprx = 16'sd100; spry = 16'sd50;
      #3;
      if (drawing) n++;
    end
    chk("no draw before first line", n, 0);

    run_line(50, 100, 50, NONE, NONE, NONE);
    chk("row0 addr@100", int'(a_addr[at(100)]), 0);
    chk("row0 addr@107", int'(a_addr[at(107)]), 7);
    chk("row0 pix@101", int'(a_pix[at(101)]), 0);
    chk("row0 drw@101", int'(a_drw[at(101)]), 0);
    chk("row0 pix@102", int'(a_pix[at(102)]), 1);
    chk("row0 drw@102", int'(a_drw[at(102)]), 1);
    chk("row0 pix@108", int'(a_pix[at(108)]), 7);
    chk("row0 drw@109", int'(a_drw[at(109)]), 0);
    chk("row0 count", drawn_from(LSTART), 7);

    run_line(53, 100, 50, NONE, NONE, NONE);
    chk("row3 addr@100", int'(a_addr[at(100)]), 24);
    chk("row3 addr@107", int'(a_addr[at(107)]), 31);
    chk("row3 pix@101", int'(a_pix[at(101)]), 8);
    chk("row3 pix@108", int'(a_pix[at(108)]), 15);
    chk("row3 count", drawn_from(LSTART), 8);

    run_line(49, 100, 50, NONE, NONE, NONE);
    chk("above sprite count", drawn_from(LSTART), 0);
    run_line(58, 100, 50, NONE, NONE, NONE);
    chk("below sprite count", drawn_from(LSTART), 0);

    run_line(0, 100, -3, NONE, NONE, NONE);
    chk("neg spry addr@100", int'(a_addr[at(100)]), 24);
    chk("neg spry pix@108", int'(a_pix[at(108)]), 15);
    chk("neg spry count", drawn_from(LSTART), 8);
    run_line(5, 100, -3, NONE, NONE, NONE);
    chk("neg spry sy=5 count", drawn_from(LSTART), 0);

    run_line(50, 100, 50, NONE, NONE, 0);
    chk("moved mid-line pix@102", int'(a_pix[at(102)]), 1);
    chk("moved mid-line count", drawn_from(LSTART), 7);

    run_line(51, -16, 50, NONE, NONE, NONE);
    chk("left edge pix@-15", int'(a_pix[at(-15)]), 8);
    chk("left edge count", drawn_from(LSTART), 8);
    run_line(51, -17, 50, NONE, NONE, NONE);
    chk("left clip count", drawn_from(LSTART), 0);

    run_line(50, 100, 50, 103, NONE, NONE);
    chk("abort pix@103", int'(a_pix[at(103)]), 2);
    chk("abort pix@104", int'(a_pix[at(104)]), 0);
    chk("abort drw@104", int'(a_drw[at(104)]), 0);
    chk("abort count after", drawn_from(104), 0);
    chk("abort count", drawn_from(LSTART), 2);

    run_line(50, 100, 50, NONE, 104, NONE);
    chk("rst pix@104", int'(a_pix[at(104)]), 0);
    chk("rst drw@104", int'(a_drw[at(104)]), 0);
    chk("rst addr@104", int'(a_addr[at(104)]), 0);
    chk("rst count after", drawn_from(104), 0);
    chk("rst count", drawn_from(LSTART), 2);

    run_line(53, 100, 50, NONE, NONE, NONE);
    chk("after rst pix@101", int'(a_pix[at(101)]), 8);
    chk("after rst count", drawn_from(LSTART), 8);

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
